// File: rtl/host_frame_tx.sv
// host_frame_tx: host-side frame driver and response collector.
// Accepts a 64-bit request on a valid/ready handshake and sends one frame on rxd/rxd_v:
// a header byte followed by the 8 request bytes, most significant byte first.
// Response bytes on txd/tx_en are shifted into rsp_data. The transaction ends with a
// rsp_valid pulse, or with a rsp_timeout pulse if the response never completes.
// Build option: define HOST_FRAME_CHKSUM_EN to append a checksum byte after the data
// bytes. The checksum is the 8-bit sum of the 8 data bytes; the header is not included.
`timescale 1ns/1ps
module host_frame_tx #(
  parameter logic [7:0] HDR_BYTE  = 8'h55,
  parameter int         GAP_CYC   = 0,
  parameter int         RSP_BYTES = 8,
  parameter int         TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] req_data,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [7:0]  rxd,
  output logic        rxd_v,
  input  logic [7:0]  txd,
  input  logic        tx_en,
  output logic [63:0] rsp_data,
  output logic        rsp_valid,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int         TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [3:0] RSP_N    = 4'(RSP_BYTES);
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
`ifdef HOST_FRAME_CHKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_GAP  = 3'd4,
    S_WAIT = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [63:0]   shift_reg;       // remaining data bytes, next one in [63:56]
  logic [3:0]    byte_cnt_reg;    // data bytes already sent, 0..8
  logic [3:0]    gap_cnt_reg;     // idle cycles spent in the current gap
  logic [3:0]    rsp_cnt_reg;     // response bytes collected
  logic [TW-1:0] timer_reg;       // cycles spent in WAIT
  logic [63:0]   rsp_reg;
  logic          rsp_valid_reg, rsp_timeout_reg;
`ifdef HOST_FRAME_CHKSUM_EN
  logic [7:0]    sum_reg;         // running sum of the data bytes sent so far
`endif

  logic accept, capture, complete, expire;
  logic valid_next, timeout_next;

  assign accept   = req_valid && req_ready;
  // The collection window opens the cycle after the header and closes in IDLE.
  assign capture  = tx_en && (state_reg != S_IDLE) && (state_reg != S_HDR) && (rsp_cnt_reg < RSP_N);
  // A byte arriving in this cycle counts, so a last byte on the expiry cycle still completes.
  assign complete = ((rsp_cnt_reg + {3'b000, capture}) == RSP_N);
  // Decided one cycle early, so the registered pulse lands in the cycle the timer reads TIMEOUT-1.
  assign expire   = (int'(timer_reg) + 2 >= TIMEOUT);

  assign rsp_data    = rsp_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_timeout = rsp_timeout_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic, byte output mux and handshake outputs.
  always_comb begin
    state_next   = state_reg;
    req_ready    = 1'b0;
    busy         = 1'b1;
    rxd_v        = 1'b0;
    rxd          = 8'h00;
    valid_next   = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = S_HDR;
      end
      S_HDR: begin
        rxd_v      = 1'b1;
        rxd        = HDR_BYTE;
        state_next = (GAP_CYC > 0) ? S_GAP : S_DATA;
      end
      S_DATA: begin
        rxd_v = 1'b1;
        rxd   = shift_reg[63:56];
        if (byte_cnt_reg == 4'd7) begin
`ifdef HOST_FRAME_CHKSUM_EN
          state_next = (GAP_CYC > 0) ? S_GAP : S_CSUM;
`else
          state_next = S_WAIT;
`endif
        end else begin
          state_next = (GAP_CYC > 0) ? S_GAP : S_DATA;
        end
      end
`ifdef HOST_FRAME_CHKSUM_EN
      S_CSUM: begin
        rxd_v      = 1'b1;
        rxd        = sum_reg;
        state_next = S_WAIT;
      end
`endif
      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
`ifdef HOST_FRAME_CHKSUM_EN
          state_next = (byte_cnt_reg == 4'd8) ? S_CSUM : S_DATA;
`else
          state_next = S_DATA;
`endif
        end
      end
      S_WAIT: begin
        if (complete) begin
          valid_next = 1'b1;
          state_next = S_IDLE;
        end else if (expire) begin
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, byte sequencing, response shift register, timer and result pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg       <= '0;
      byte_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      rsp_cnt_reg     <= '0;
      timer_reg       <= '0;
      rsp_reg         <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
`ifdef HOST_FRAME_CHKSUM_EN
      sum_reg         <= '0;
`endif
    end else begin
      if (accept) begin
        shift_reg    <= req_data;
        byte_cnt_reg <= '0;
        rsp_cnt_reg  <= '0;
        rsp_reg      <= '0;
`ifdef HOST_FRAME_CHKSUM_EN
        sum_reg      <= '0;
`endif
      end else if (state_reg == S_DATA) begin
        shift_reg <= {shift_reg[55:0], 8'h00};
        if (byte_cnt_reg != 4'd8) byte_cnt_reg <= byte_cnt_reg + 4'd1;
`ifdef HOST_FRAME_CHKSUM_EN
        sum_reg   <= sum_reg + shift_reg[63:56];
`endif
      end
      if (capture) begin
        rsp_reg     <= {rsp_reg[55:0], txd};
        rsp_cnt_reg <= rsp_cnt_reg + 4'd1;
      end
      if (state_reg != S_GAP)        gap_cnt_reg <= '0;
      else if (gap_cnt_reg != 4'hF)  gap_cnt_reg <= gap_cnt_reg + 4'd1;
      if (state_reg != S_WAIT)              timer_reg <= '0;
      else if (int'(timer_reg) < TIMEOUT)   timer_reg <= timer_reg + 1'b1;
      rsp_valid_reg   <= valid_next;
      rsp_timeout_reg <= timeout_next;
    end
  end

endmodule

// File: tb/tb_host_frame_tx.sv
// Scoreboard bench for host_frame_tx: expected frame bytes and responses are queued at
// request time and popped by a negedge monitor. A second instance with GAP_CYC=2 is
// checked for the byte spacing pattern.
`timescale 1ns/1ps
module tb_host_frame_tx;
  localparam int TIMEOUT = 16;
`ifdef HOST_FRAME_CHKSUM_EN
  localparam int FRAME_LEN = 10;
`else
  localparam int FRAME_LEN = 9;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] req_data;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  rxd;
  logic        rxd_v;
  logic [7:0]  txd = 8'h00;
  logic        tx_en = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_valid, rsp_timeout, busy;

  logic [63:0] g_req_data;
  logic        g_req_valid;
  logic        g_req_ready;
  logic [7:0]  g_rxd;
  logic        g_rxd_v;
  logic [7:0]  g_txd = 8'h00;
  logic        g_tx_en = 1'b0;
  logic [63:0] g_rsp_data;
  logic        g_rsp_valid, g_rsp_timeout, g_busy;

  host_frame_tx #(.HDR_BYTE(8'h55), .GAP_CYC(0), .RSP_BYTES(8), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .rxd(rxd), .rxd_v(rxd_v), .txd(txd), .tx_en(tx_en), .rsp_data(rsp_data),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .busy(busy));

  host_frame_tx #(.HDR_BYTE(8'h55), .GAP_CYC(2), .RSP_BYTES(8), .TIMEOUT(TIMEOUT)) u_gap (
    .clk(clk), .rst_n(rst_n), .req_data(g_req_data), .req_valid(g_req_valid), .req_ready(g_req_ready),
    .rxd(g_rxd), .rxd_v(g_rxd_v), .txd(g_txd), .tx_en(g_tx_en), .rsp_data(g_rsp_data),
    .rsp_valid(g_rsp_valid), .rsp_timeout(g_rsp_timeout), .busy(g_busy));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic        is_to;
    logic [63:0] data;
  } rsp_t;

  logic [7:0] exp_tx_q[$];
  rsp_t       exp_rsp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte idx of the frame for request w: header, data MSB-first, then checksum.
  function automatic logic [7:0] frame_byte(input logic [63:0] w, input int idx);
    logic [7:0] s;
    s = 8'h00;
    if (idx == 0) return 8'h55;
    if (idx <= 8) return w[63 - 8*(idx-1) -: 8];
    for (int i = 0; i < 8; i++) s = s + w[63 - 8*i -: 8];
    return s;
  endfunction

  // Cycle counter.
  always @(posedge clk) cyc++;

  // Responder model: 0 silent, 1 echo one cycle later, 2 echo 7 bytes then a late last byte.
  int         mode = 1;
  int         since = 0;
  int         late_cnt = 0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  always @(negedge clk) begin
    hold_v = 1'b0;
    hold_d = 8'h00;
    if (rxd_v) since = 0;
    else if (since < 1000) since++;
    if (mode != 2) late_cnt = 0;
    if (mode == 1 && rxd_v) begin
      hold_v = 1'b1;
      hold_d = rxd;
    end
    if (mode == 2) begin
      if (rxd_v && late_cnt < 7) begin
        hold_v = 1'b1;
        hold_d = rxd;
        late_cnt++;
      end else if (!rxd_v && late_cnt == 7 && since == TIMEOUT - 2) begin
        hold_v = 1'b1;
        hold_d = 8'hAA;
        late_cnt = 8;
      end
    end
  end

  // Responder drive, just after the active edge.
  always @(posedge clk) begin
    #1;
    tx_en = hold_v;
    txd   = hold_d;
  end

  // Monitor: checks frame bytes, idle rxd, frame length and response pulses.
  int   run = 0;
  int   last_v_cyc = 0;
  rsp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (rxd_v) begin
        run++;
        last_v_cyc = cyc;
        if (exp_tx_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tx_unexpected: got byte %0h, expected no byte", rxd);
        end else begin
          chk("tx_byte", {56'h0, rxd}, {56'h0, exp_tx_q.pop_front()});
        end
      end else begin
        chk("rxd_idle_zero", {56'h0, rxd}, 64'h0);
        if (run != 0) begin
          chk("frame_len", run, FRAME_LEN);
          run = 0;
        end
      end
      if (rsp_valid || rsp_timeout) begin
        if (exp_rsp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: got valid=%0b timeout=%0b, expected no pulse", rsp_valid, rsp_timeout);
        end else begin
          mon_e = exp_rsp_q.pop_front();
          $display("rsp: valid=%0b timeout=%0b data=%016h", rsp_valid, rsp_timeout, rsp_data);
          chk("rsp_valid", {63'h0, rsp_valid}, {63'h0, !mon_e.is_to});
          chk("rsp_timeout", {63'h0, rsp_timeout}, {63'h0, mon_e.is_to});
          chk("rsp_data", rsp_data, mon_e.data);
          if (mon_e.is_to) chk("timeout_latency", cyc - last_v_cyc, TIMEOUT);
        end
      end
    end
  end

  task automatic send_req(input logic [63:0] w, input logic is_to, input logic [63:0] rdata);
    int   k;
    rsp_t r;
    k = 0;
    while (!req_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_ready_wait", {63'h0, req_ready}, 64'h1);
    for (int i = 0; i < FRAME_LEN; i++) exp_tx_q.push_back(frame_byte(w, i));
    r.is_to = is_to;
    r.data  = rdata;
    exp_rsp_q.push_back(r);
    req_data  = w;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("req: data=%016h mode=%0d", w, mode);
    chk("ready_low_after_accept", {63'h0, req_ready}, 64'h0);
    chk("busy_after_accept", {63'h0, busy}, 64'h1);
    chk("hdr_next_cycle", {55'h0, rxd_v, rxd}, {55'h0, 1'b1, 8'h55});
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_rsp_q.size() != 0 || exp_tx_q.size() != 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_rsp", exp_rsp_q.size(), 0);
    chk("drain_tx", exp_tx_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int   gk, nh, last_k, first_k, to_k;
  logic ready_seen, to_seen;

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_data    = '0;
    g_req_valid = 1'b0;
    g_req_data  = '0;
    mode        = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_rxd", {55'h0, rxd_v, rxd}, 64'h0);
    chk("rst_pulses", {62'h0, rsp_valid, rsp_timeout}, 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_gap_ready", {63'h0, g_req_ready}, 64'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Echo responder: first 8 echoes are the header and bytes 01..07.
    mode = 1;
    send_req(64'h0102030405060708, 1'b0, 64'h5501020304050607);
    drain();
    chk("rsp_hold_idle", rsp_data, 64'h5501020304050607);
    chk("idle_ready", {63'h0, req_ready}, 64'h1);
    send_req(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h55FFFFFFFFFFFFFF);
    drain();
    send_req(64'h8040201008040201, 1'b0, 64'h5580402010080402);
    drain();

    // Silent responder: timeout TIMEOUT cycles after the last byte, empty response.
    mode = 0;
    send_req(64'hDEADBEEF00C0FFEE, 1'b1, 64'h0);
    drain();

    // Last response byte lands on the expiry cycle: completion wins.
    mode = 2;
    send_req(64'h0102030405060708, 1'b0, 64'h55010203040506AA);
    drain();

    // Gapped instance: one high every 3 cycles, ready low until back in IDLE.
    while (!g_req_ready) begin
      @(posedge clk); #1;
    end
    g_req_data  = 64'h0102030405060708;
    g_req_valid = 1'b1;
    @(posedge clk); #1;
    g_req_valid = 1'b0;
    $display("req: gap instance data=%016h", g_req_data);
    gk = 0; nh = 0; last_k = -1; first_k = -1; to_k = 0;
    ready_seen = 1'b0; to_seen = 1'b0;
    while (!to_seen && gk < 400) begin
      if (g_rsp_timeout) begin
        to_seen = 1'b1;
        to_k    = gk;
      end else begin
        if (g_req_ready) ready_seen = 1'b1;
        if (g_rxd_v) begin
          if (nh < FRAME_LEN) chk("gap_byte", {56'h0, g_rxd}, {56'h0, frame_byte(64'h0102030405060708, nh)});
          if (nh == 0) first_k = gk;
          else chk("gap_spacing", gk - last_k, 3);
          last_k = gk;
          nh++;
        end
        @(posedge clk); #1;
        gk++;
      end
    end
    chk("gap_high_count", nh, FRAME_LEN);
    chk("gap_first_cycle", first_k, 0);
    chk("gap_ready_low_while_busy", {63'h0, ready_seen}, 64'h0);
    chk("gap_timeout_seen", {63'h0, to_seen}, 64'h1);
    chk("gap_timeout_latency", to_k - last_k, TIMEOUT);
    chk("gap_no_valid", {63'h0, g_rsp_valid}, 64'h0);
    chk("gap_rsp_data", g_rsp_data, 64'h0);
    @(posedge clk); #1;
    chk("gap_ready_back", {63'h0, g_req_ready}, 64'h1);

    // Reset on the 4th data byte, then a clean frame.
    mode = 1;
    send_req(64'h1122334455667788, 1'b0, 64'h0);
    gk = 0;
    while (!(rxd_v && rxd == 8'h44) && gk < 50) begin
      @(posedge clk); #1;
      gk++;
    end
    chk("reset_point_found", {55'h0, rxd_v, rxd}, {55'h0, 1'b1, 8'h44});
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_tx_q.delete();
    exp_rsp_q.delete();
    $display("req: reset applied mid-frame");
    chk("midrst_rxd_v", {63'h0, rxd_v}, 64'h0);
    chk("midrst_req_ready", {63'h0, req_ready}, 64'h1);
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    chk("midrst_pulses", {62'h0, rsp_valid, rsp_timeout}, 64'h0);
    chk("midrst_rsp_data", rsp_data, 64'h0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    send_req(64'h0A0B0C0D0E0F1011, 1'b0, 64'h550A0B0C0D0E0F10);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion within time limit");
    $fatal(1, "time limit");
  end

endmodule
